// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the load/store sequencer: request, byte lanes and ready handshake.
// Master drives the cycle; slave answers with mem_ready and mem_rdata.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: alignment check, lane steering, ready wait with timeout.
// Latency: done one cycle after mem_ready; control stalls on busy, req ignored unless idle.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        ls_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  mem_access_ctrl_if.master mem,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic              bus_err,
  output logic [31:0]       bad_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t      state;
  logic        is_store_q;
  logic [2:0]  ls_type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt;

  logic        in_half, in_byte, misaligned;
  logic        q_half, q_byte, q_unsigned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic        timeout_hit;

  // Codes 101..111 fall through to word handling.
  always_comb begin
    in_half    = (ls_type == 3'b001) || (ls_type == 3'b010);
    in_byte    = (ls_type == 3'b011) || (ls_type == 3'b100);
    misaligned = in_half ? addr[0] : (!in_byte && (addr[1:0] != 2'b00));
    q_half     = (ls_type_q == 3'b001) || (ls_type_q == 3'b010);
    q_byte     = (ls_type_q == 3'b011) || (ls_type_q == 3'b100);
    q_unsigned = (ls_type_q == 3'b010) || (ls_type_q == 3'b100);
  end

  always_comb begin
    byte_sel = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    if (q_byte)
      load_val = {{24{!q_unsigned && byte_sel[7]}}, byte_sel};
    else if (q_half)
      load_val = {{16{!q_unsigned && half_sel[15]}}, half_sel};
    else
      load_val = mem.mem_rdata;
  end

  always_comb begin
    mem.mem_req   = (state == ACCESS);
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'd0;
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = 32'd0;
    if (state == ACCESS) begin
      mem.mem_we   = is_store_q;
      mem.mem_addr = {addr_q[31:2], 2'b00};
      if (!is_store_q)
        mem.mem_be = 4'b1111;
      else if (q_byte)
        mem.mem_be = 4'b0001 << addr_q[1:0];
      else if (q_half)
        mem.mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
      else
        mem.mem_be = 4'b1111;
      if (q_byte)
        mem.mem_wdata = {4{wdata_q[7:0]}};
      else if (q_half)
        mem.mem_wdata = {2{wdata_q[15:0]}};
      else
        mem.mem_wdata = wdata_q;
    end
  end

  // Ready in the final wait cycle takes priority over the timeout.
  assign timeout_hit = (state == ACCESS) && !mem.mem_ready && (cnt == 8'(TIMEOUT - 1));
  assign bus_err     = timeout_hit;
  assign busy        = (state != IDLE);
  assign done        = (state == RESP);
  assign addr_err    = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      ls_type_q  <= 3'b000;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cnt        <= 8'd0;
      rdata      <= 32'd0;
      bad_addr   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_store_q <= is_store;
            ls_type_q  <= ls_type;
            addr_q     <= addr;
            wdata_q    <= wdata;
            cnt        <= 8'd0;
            state      <= misaligned ? ERR : ACCESS;
          end
        end
        ACCESS: begin
          if (mem.mem_ready) begin
            if (!is_store_q)
              rdata <= load_val;
            state <= RESP;
          end else if (timeout_hit) begin
            bad_addr <= addr_q;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: state <= IDLE;
        ERR: begin
          bad_addr <= addr_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded bench for mem_access_ctrl with a 4-cycle timeout and a scripted memory model.
module tb_mem_access_ctrl;
  localparam int TO_P = 4;
  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;
  localparam logic [2:0] K_DONE = 3'b100, K_AERR = 3'b010, K_BERR = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] rdata;
  } exp_t;

  logic        clk, rst_n, req, is_store;
  logic [2:0]  ls_type;
  logic [31:0] addr, wdata;
  logic        busy, done, addr_err, bus_err;
  logic [31:0] rdata, bad_addr;

  mem_access_ctrl_if mem_bus ();

  mem_access_ctrl #(.TIMEOUT(TO_P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .is_store (is_store),
    .ls_type  (ls_type),
    .addr     (addr),
    .wdata    (wdata),
    .mem      (mem_bus.master),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .addr_err (addr_err),
    .bus_err  (bus_err),
    .bad_addr (bad_addr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_rd = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every done/error pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (done || addr_err || bus_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, done, addr_err, bus_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_kind", {29'd0, done, addr_err, bus_err}, {29'd0, mon_e.kind});
        chk("resp_rdata", rdata, mon_e.rdata);
      end
    end
  end

  task automatic access(input logic st, input logic [2:0] lt, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int rdy,
                        input logic [2:0] kind, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] erd);
    exp_t e;
    int   last;
    e.kind  = kind;
    e.rdata = (kind == K_DONE && !st) ? erd : last_rd;
    last_rd = e.rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; is_store = st; ls_type = lt; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom; wdata = $urandom;
    if (kind == K_AERR) begin
      @(negedge clk);
      chk("aerr_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
      chk("aerr_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("aerr_bad_addr", bad_addr, a);
      chk("aerr_idle", {31'd0, busy}, 32'd0);
      chk("aerr_mem_req2", {31'd0, mem_bus.mem_req}, 32'd0);
    end else begin
      last = (kind == K_BERR) ? TO_P : rdy;
      for (int c = 1; c <= last; c++) begin
        mem_bus.mem_ready = (c == rdy);
        mem_bus.mem_rdata = rd;
        @(negedge clk);
        chk("acc_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("acc_mem_we", {31'd0, mem_bus.mem_we}, {31'd0, st});
        chk("acc_mem_addr", mem_bus.mem_addr, {a[31:2], 2'b00});
        chk("acc_mem_be", {28'd0, mem_bus.mem_be}, {28'd0, ebe});
        chk("acc_mem_wdata", mem_bus.mem_wdata, ewd);
        chk("acc_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
      end
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("post_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
      chk("post_mem_be", {28'd0, mem_bus.mem_be}, 32'd0);
      if (kind == K_DONE) begin
        chk("resp_busy", {31'd0, busy}, 32'd1);
      end else begin
        chk("berr_idle", {31'd0, busy}, 32'd0);
        chk("berr_bad_addr", bad_addr, a);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("end_busy", {31'd0, busy}, 32'd0);
    end
    chk("resp_seen", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; ls_type = LW; addr = 32'd0; wdata = 32'd0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'd0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_bus.mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {29'd0, done, addr_err, bus_err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bad_addr", bad_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Loads, lane extraction and sign/zero extension.
    access(0, LB,  32'h1003, 32'h0, 32'h80FF1234, 1, K_DONE, 4'b1111, 32'h0, 32'hFFFFFF80);
    access(0, LBU, 32'h1003, 32'h0, 32'h80FF1234, 1, K_DONE, 4'b1111, 32'h0, 32'h00000080);
    access(0, LHU, 32'h2001, 32'h0, 32'h0,        0, K_AERR, 4'b0000, 32'h0, 32'h0);
    // Stores: lane enables and replicated data.
    access(1, LH,  32'h3002, 32'h1234ABCD, 32'h0, 1, K_DONE, 4'b1100, 32'hABCDABCD, 32'h0);
    access(1, LB,  32'h3001, 32'h00000077, 32'h0, 2, K_DONE, 4'b0010, 32'h77777777, 32'h0);
    access(1, LBU, 32'h3003, 32'hFFFFFF5A, 32'h0, 1, K_DONE, 4'b1000, 32'h5A5A5A5A, 32'h0);
    access(1, LW,  32'h7004, 32'hCAFEF00D, 32'h0, 3, K_DONE, 4'b1111, 32'hCAFEF00D, 32'h0);
    access(1, LW,  32'h7002, 32'hCAFEF00D, 32'h0, 0, K_AERR, 4'b0000, 32'h0, 32'h0);
    access(0, 3'b111, 32'h7001, 32'h0, 32'h0,     0, K_AERR, 4'b0000, 32'h0, 32'h0);
    // Wait states, timeout, and ready in the timeout cycle.
    access(0, LH,  32'h4002, 32'h0, 32'h8001FFFF, 4, K_DONE, 4'b1111, 32'h0, 32'hFFFF8001);
    access(0, LW,  32'h5000, 32'h0, 32'h0,        0, K_BERR, 4'b1111, 32'h0, 32'h0);
    access(0, LW,  32'h5004, 32'h0, 32'hDEADBEEF, 4, K_DONE, 4'b1111, 32'h0, 32'hDEADBEEF);
    access(0, LHU, 32'h6000, 32'h0, 32'h8001FFFF, 1, K_DONE, 4'b1111, 32'h0, 32'h0000FFFF);
    access(0, LH,  32'h6000, 32'h0, 32'h8001FFFF, 2, K_DONE, 4'b1111, 32'h0, 32'hFFFFFFFF);
    access(0, LBU, 32'h6002, 32'h0, 32'h8001FFFF, 1, K_DONE, 4'b1111, 32'h0, 32'h00000001);
    access(0, 3'b101, 32'h6004, 32'h0, 32'h13579BDF, 1, K_DONE, 4'b1111, 32'h0, 32'h13579BDF);

    // mem_ready while idle must not start or finish anything.
    @(posedge clk); #1;
    mem_bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready_busy", {31'd0, busy}, 32'd0);
      chk("idle_ready_req", {31'd0, mem_bus.mem_req}, 32'd0);
    end
    chk("idle_ready_rdata", rdata, last_rd);
    @(posedge clk); #1;
    mem_bus.mem_ready = 1'b0;

    // Reset in the middle of a wait-state load.
    @(posedge clk); #1;
    req = 1'b1; is_store = 1'b0; ls_type = LW; addr = 32'h8000;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    last_rd = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("after_rst_busy", {31'd0, busy}, 32'd0);
    end
    access(0, LW, 32'h8000, 32'h0, 32'h12345678, 2, K_DONE, 4'b1111, 32'h0, 32'h12345678);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
